ewrapper_emesh_tx_queue: RTL and testbench
==========================================

# ewrapper_emesh_tx_queue

Transmit-side eMesh queue that sits directly upstream of the eLink wrapper's `emesh_*_outb` inputs. It buffers host-originated write and read-request transactions in two separate FIFOs. It arbitrates between them round-robin, and issues one transaction per cycle while honouring the link's `emesh_wr_wait_inb` / `emesh_rd_wait_inb` back-pressure. Overflowing pushes are dropped and flagged.

## Interface
Parameters:
- `DEPTH`, 8: entries per queue; power of two, 2..64.
- `AW`, 3: pointer width, equal to log2(`DEPTH`).

Ports:
- `emesh_clk_inb`  in  1  sole clock; all state on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `host_access`  in  1  push strobe; one transaction per high cycle.
- `host_write`  in  1  1 = write (write queue), 0 = read request (read queue).
- `host_datamode`  in  2  eMesh datamode.
- `host_ctrlmode`  in  4  eMesh ctrlmode.
- `host_dstaddr`  in  32  destination address.
- `host_srcaddr`  in  32  source/return address.
- `host_data`  in  32  write data.
- `wr_full`  out  1  write queue holds `DEPTH` entries.
- `rd_full`  out  1  read queue holds `DEPTH` entries.
- `ovf_err`  out  1  sticky; set by any dropped push.
- `ovf_clr`  in  1  clears `ovf_err`.
- `emesh_access_outb`, `emesh_write_outb`  out  1 each  issued transaction.
- `emesh_datamode_outb`  out  2  issued transaction.
- `emesh_ctrlmode_outb`  out  4  issued transaction.
- `emesh_dstaddr_outb`, `emesh_srcaddr_outb`, `emesh_data_outb`  out  32 each  issued transaction.
- `emesh_wr_wait_inb`  in  1  link back-pressure for writes.
- `emesh_rd_wait_inb`  in  1  link back-pressure for read requests.
- `wr_issue_cnt`, `rd_issue_cnt`  out  16 each  issue counters (see Configuration).

## Operation
- Each queue entry is 103 bits: `{write, datamode, ctrlmode, dstaddr, srcaddr, data}`.
- Each queue is a circular buffer. Pointers are `AW` bits and wrap from `DEPTH`-1 to 0. Each queue has a count of `AW`+1 bits.
- Push: when `host_access` is high, the entry goes to the queue selected by `host_write`.
  - If that queue is full at the edge, the entry is dropped and `ovf_err` sets.
  - This applies even if a pop from the same queue happens on the same edge.
  - The other queue is unaffected.
- Eligibility:
  - The write queue is eligible when it is non-empty and `emesh_wr_wait_inb` is 0.
  - The read queue is eligible when it is non-empty and `emesh_rd_wait_inb` is 0.
- Arbitration, decided each edge:
  - If exactly one queue is eligible, it is granted.
  - If both are eligible, the queue that was not granted last is granted.
  - `last_grant` updates only on a grant. Its reset value is "read", so the write queue wins the first tie.
- Issue: the granted queue pops its head into the output register and `emesh_access_outb` is driven to 1. With no grant, `emesh_access_outb` is driven to 0.
- Output fields hold their last value while `emesh_access_outb` is 0.
- Push and pop on the same queue in the same edge: count is unchanged and both pointers advance. When empty, a push is not visible to the pop on that same edge.
- There is no ordering guarantee between the write and read classes. Order within each class is strict FIFO.
- `ovf_err`: `ovf_clr` and a drop on the same edge leave it 1, because set wins.

## Timing
- Reset values:
  - All `emesh_*_outb` outputs are 0.
  - `wr_full` and `rd_full` are 0.
  - `ovf_err` is 0.
  - Both counters are 0.
  - Pointers and counts are 0; `last_grant` is "read".
- Reset mid-operation: all queued entries are discarded, and `emesh_access_outb` is 0 in the cycle after the reset edge.
- Latency: a push sampled at edge k is issued at edge k+1 at the earliest. `emesh_access_outb` is then high during the cycle following edge k+1.
- Throughput: at most one issue per cycle across both queues, and one push per cycle.
- The wait inputs are sampled at the same edge as the grant decision. A wait input that rises at edge k blocks that class's issue from edge k onward.
- `wr_full` and `rd_full` are registered-state decodes (count == `DEPTH`) and are valid in the same cycle as the count.

## Configuration
- Macro: `EWRAPPER_TXQ_CNT_EN`.
- Defined:
  - `wr_issue_cnt` and `rd_issue_cnt` each increment by 1 on every issue from their queue.
  - They wrap from 0xFFFF to 0x0000 and are cleared by `reset`.
- Undefined: both counters are tied to 0 and no counter flops exist.

## Test plan
- Single write: push write with dst=0x80800000, data=0xDEADBEEF, and both waits 0. Required: `emesh_access_outb`=1 for exactly one cycle, two edges later, carrying the same fields and `emesh_write_outb`=1.
- Fill/overflow (`DEPTH`=8): push 9 writes with `emesh_wr_wait_inb`=1. Required:
  - `wr_full`=1 after the 8th push and `ovf_err`=1 after the 9th.
  - Releasing the wait issues exactly 8 writes, in order, on 8 consecutive cycles.
- Round-robin: preload 3 writes and 3 reads, then drop both waits. Required: issue order W,R,W,R,W,R.
- Independent back-pressure: `emesh_rd_wait_inb`=1 with both queues loaded. Required: only writes issue, and reads follow after the wait drops.
- Reset mid-burst: assert `reset` with 5 entries queued. Required: `emesh_access_outb`=0 the next cycle, no stale issue afterwards, and both full flags 0.
- With `EWRAPPER_TXQ_CNT_EN` defined: 0x10001 writes issued. Required: `wr_issue_cnt`=0x0001 and `rd_issue_cnt`=0.

Source files
------------

// File: rtl/ewrapper_emesh_tx_queue.sv
// ---------------------------------------------------------------------------
// ewrapper_emesh_tx_queue
//
// Transmit-side eMesh queue in front of the eLink wrapper emesh_*_outb inputs.
// Host writes and host read requests are buffered in two independent circular
// FIFOs. A round-robin arbiter issues at most one transaction per cycle into a
// registered output stage, and honours per-class link back-pressure.
//
// Optional feature: define EWRAPPER_TXQ_CNT_EN to build the 16-bit issue
// counters. Without it, wr_issue_cnt/rd_issue_cnt are tied to 0.
//
// Ports:
//   emesh_clk_inb        sole clock, rising edge
//   reset                synchronous, active-high
//   host_access          push strobe, one transaction per high cycle
//   host_write           1 = write queue, 0 = read-request queue
//   host_datamode/ctrlmode/dstaddr/srcaddr/data   transaction fields
//   wr_full / rd_full    queue holds DEPTH entries
//   ovf_err              sticky drop flag, cleared by ovf_clr (set wins)
//   emesh_*_outb         registered issued transaction
//   emesh_wr_wait_inb    link back-pressure for writes
//   emesh_rd_wait_inb    link back-pressure for read requests
//   wr_issue_cnt / rd_issue_cnt   per-class issue counters
//
// Handshake semantics: host_access is a valid with no ready; a push into a
// queue that is full at the sampling edge is dropped and flags ovf_err. On
// the link side a class may issue on an edge where it is non-empty and its
// wait input is low; emesh_access_outb is the valid of the registered output
// for the following cycle, and the output fields hold while it is low.
// ---------------------------------------------------------------------------
module ewrapper_emesh_tx_queue #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic        emesh_clk_inb,
    input  logic        reset,
    input  logic        host_access,
    input  logic        host_write,
    input  logic [1:0]  host_datamode,
    input  logic [3:0]  host_ctrlmode,
    input  logic [31:0] host_dstaddr,
    input  logic [31:0] host_srcaddr,
    input  logic [31:0] host_data,
    output logic        wr_full,
    output logic        rd_full,
    output logic        ovf_err,
    input  logic        ovf_clr,
    output logic        emesh_access_outb,
    output logic        emesh_write_outb,
    output logic [1:0]  emesh_datamode_outb,
    output logic [3:0]  emesh_ctrlmode_outb,
    output logic [31:0] emesh_dstaddr_outb,
    output logic [31:0] emesh_srcaddr_outb,
    output logic [31:0] emesh_data_outb,
    input  logic        emesh_wr_wait_inb,
    input  logic        emesh_rd_wait_inb,
    output logic [15:0] wr_issue_cnt,
    output logic [15:0] rd_issue_cnt
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    // Arbiter state: which class was granted most recently.
    localparam logic GRANT_RD = 1'b0;
    localparam logic GRANT_WR = 1'b1;

    // Entry layout: {write, datamode, ctrlmode, dstaddr, srcaddr, data}
    logic [102:0] host_entry;
    assign host_entry = {host_write, host_datamode, host_ctrlmode,
                         host_dstaddr, host_srcaddr, host_data};

    logic [102:0]  wr_mem [DEPTH];
    logic [102:0]  rd_mem [DEPTH];
    logic [AW-1:0] wr_wptr, wr_rptr, rd_wptr, rd_rptr;
    logic [AW:0]   wr_count, rd_count;
    logic          last_grant;
    logic [102:0]  out_q;

    logic wr_push, rd_push, push_drop;
    logic wr_elig, rd_elig, grant_wr, grant_rd;

    assign wr_full = (wr_count == FULL_CNT);
    assign rd_full = (rd_count == FULL_CNT);

    // Fullness is judged on the registered count, so a same-edge pop never
    // makes room for a push.
    assign wr_push   = host_access &  host_write & ~wr_full;
    assign rd_push   = host_access & ~host_write & ~rd_full;
    assign push_drop = host_access & (host_write ? wr_full : rd_full);

    // Eligibility uses the registered count, so a push is never visible to a
    // pop on the same edge.
    assign wr_elig = (wr_count != '0) & ~emesh_wr_wait_inb;
    assign rd_elig = (rd_count != '0) & ~emesh_rd_wait_inb;

    assign grant_wr = wr_elig & (~rd_elig | (last_grant == GRANT_RD));
    assign grant_rd = rd_elig & (~wr_elig | (last_grant == GRANT_WR));

    // Storage has no reset; validity is tracked by the pointers and counts.
    always_ff @(posedge emesh_clk_inb) begin
        if (wr_push) wr_mem[wr_wptr] <= host_entry;
        if (rd_push) rd_mem[rd_wptr] <= host_entry;
    end

    always_ff @(posedge emesh_clk_inb) begin
        if (reset) begin
            wr_wptr  <= '0;
            wr_rptr  <= '0;
            wr_count <= '0;
        end else begin
            if (wr_push)  wr_wptr <= wr_wptr + PTR_ONE;
            if (grant_wr) wr_rptr <= wr_rptr + PTR_ONE;
            case ({wr_push, grant_wr})
                2'b10:   wr_count <= wr_count + CNT_ONE;
                2'b01:   wr_count <= wr_count - CNT_ONE;
                default: wr_count <= wr_count;
            endcase
        end
    end

    always_ff @(posedge emesh_clk_inb) begin
        if (reset) begin
            rd_wptr  <= '0;
            rd_rptr  <= '0;
            rd_count <= '0;
        end else begin
            if (rd_push)  rd_wptr <= rd_wptr + PTR_ONE;
            if (grant_rd) rd_rptr <= rd_rptr + PTR_ONE;
            case ({rd_push, grant_rd})
                2'b10:   rd_count <= rd_count + CNT_ONE;
                2'b01:   rd_count <= rd_count - CNT_ONE;
                default: rd_count <= rd_count;
            endcase
        end
    end

    always_ff @(posedge emesh_clk_inb) begin
        if (reset) begin
            last_grant        <= GRANT_RD;
            out_q             <= '0;
            emesh_access_outb <= 1'b0;
        end else begin
            emesh_access_outb <= grant_wr | grant_rd;
            if (grant_wr) begin
                out_q      <= wr_mem[wr_rptr];
                last_grant <= GRANT_WR;
            end else if (grant_rd) begin
                out_q      <= rd_mem[rd_rptr];
                last_grant <= GRANT_RD;
            end
        end
    end

    // Set has priority over clear.
    always_ff @(posedge emesh_clk_inb) begin
        if (reset)          ovf_err <= 1'b0;
        else if (push_drop) ovf_err <= 1'b1;
        else if (ovf_clr)   ovf_err <= 1'b0;
    end

    assign emesh_write_outb    = out_q[102];
    assign emesh_datamode_outb = out_q[101:100];
    assign emesh_ctrlmode_outb = out_q[99:96];
    assign emesh_dstaddr_outb  = out_q[95:64];
    assign emesh_srcaddr_outb  = out_q[63:32];
    assign emesh_data_outb     = out_q[31:0];

`ifdef EWRAPPER_TXQ_CNT_EN
    logic [15:0] wr_cnt_q, rd_cnt_q;

    always_ff @(posedge emesh_clk_inb) begin
        if (reset) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
        end else begin
            if (grant_wr) wr_cnt_q <= wr_cnt_q + 16'd1;
            if (grant_rd) rd_cnt_q <= rd_cnt_q + 16'd1;
        end
    end

    assign wr_issue_cnt = wr_cnt_q;
    assign rd_issue_cnt = rd_cnt_q;
`else
    assign wr_issue_cnt = 16'h0000;
    assign rd_issue_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ewrapper_emesh_tx_queue.sv
// ---------------------------------------------------------------------------
// Bench for ewrapper_emesh_tx_queue. A queue-based reference model predicts
// every output after every edge; directed scenarios are followed by a
// randomized phase.
// ---------------------------------------------------------------------------
module tb_ewrapper_emesh_tx_queue;

    localparam int DEPTH = 8;
    localparam int AW    = 3;

    typedef logic [102:0] entry_t;

    // ---------------- clock / reset block ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        host_access = 1'b0;
    logic        host_write = 1'b0;
    logic [1:0]  host_datamode = '0;
    logic [3:0]  host_ctrlmode = '0;
    logic [31:0] host_dstaddr = '0;
    logic [31:0] host_srcaddr = '0;
    logic [31:0] host_data = '0;
    logic        ovf_clr = 1'b0;
    logic        emesh_wr_wait_inb = 1'b0;
    logic        emesh_rd_wait_inb = 1'b0;

    logic        wr_full, rd_full, ovf_err;
    logic        emesh_access_outb, emesh_write_outb;
    logic [1:0]  emesh_datamode_outb;
    logic [3:0]  emesh_ctrlmode_outb;
    logic [31:0] emesh_dstaddr_outb, emesh_srcaddr_outb, emesh_data_outb;
    logic [15:0] wr_issue_cnt, rd_issue_cnt;

    ewrapper_emesh_tx_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .emesh_clk_inb       (clk),
        .reset               (reset),
        .host_access         (host_access),
        .host_write          (host_write),
        .host_datamode       (host_datamode),
        .host_ctrlmode       (host_ctrlmode),
        .host_dstaddr        (host_dstaddr),
        .host_srcaddr        (host_srcaddr),
        .host_data           (host_data),
        .wr_full             (wr_full),
        .rd_full             (rd_full),
        .ovf_err             (ovf_err),
        .ovf_clr             (ovf_clr),
        .emesh_access_outb   (emesh_access_outb),
        .emesh_write_outb    (emesh_write_outb),
        .emesh_datamode_outb (emesh_datamode_outb),
        .emesh_ctrlmode_outb (emesh_ctrlmode_outb),
        .emesh_dstaddr_outb  (emesh_dstaddr_outb),
        .emesh_srcaddr_outb  (emesh_srcaddr_outb),
        .emesh_data_outb     (emesh_data_outb),
        .emesh_wr_wait_inb   (emesh_wr_wait_inb),
        .emesh_rd_wait_inb   (emesh_rd_wait_inb),
        .wr_issue_cnt        (wr_issue_cnt),
        .rd_issue_cnt        (rd_issue_cnt)
    );

    // ---------------- reference model ----------------
    entry_t      exp_wr_q[$];
    entry_t      exp_rd_q[$];
    logic        m_last_was_wr;
    entry_t      m_out;
    logic        m_access;
    logic        m_ovf;
    logic [15:0] m_wr_cnt, m_rd_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int issues_seen = 0;
    logic [15:0] order_log = '0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance the model by one edge using the inputs currently applied.
    task automatic model_edge();
        bit we, re, gw, gr, wfull, rfull, drop;
        if (reset) begin
            exp_wr_q.delete();
            exp_rd_q.delete();
            m_last_was_wr = 1'b0;
            m_out = '0;
            m_access = 1'b0;
            m_ovf = 1'b0;
            m_wr_cnt = '0;
            m_rd_cnt = '0;
            return;
        end
        wfull = (exp_wr_q.size() == DEPTH);
        rfull = (exp_rd_q.size() == DEPTH);
        we = (exp_wr_q.size() != 0) && !emesh_wr_wait_inb;
        re = (exp_rd_q.size() != 0) && !emesh_rd_wait_inb;
        gw = we && (!re || !m_last_was_wr);
        gr = re && (!we ||  m_last_was_wr);
        m_access = gw || gr;
        if (gw) begin
            m_out = exp_wr_q.pop_front();
            m_last_was_wr = 1'b1;
`ifdef EWRAPPER_TXQ_CNT_EN
            m_wr_cnt = m_wr_cnt + 16'd1;
`endif
        end else if (gr) begin
            m_out = exp_rd_q.pop_front();
            m_last_was_wr = 1'b0;
`ifdef EWRAPPER_TXQ_CNT_EN
            m_rd_cnt = m_rd_cnt + 16'd1;
`endif
        end
        drop = 1'b0;
        if (host_access) begin
            if (host_write) begin
                if (wfull) drop = 1'b1;
                else exp_wr_q.push_back({host_write, host_datamode, host_ctrlmode,
                                         host_dstaddr, host_srcaddr, host_data});
            end else begin
                if (rfull) drop = 1'b1;
                else exp_rd_q.push_back({host_write, host_datamode, host_ctrlmode,
                                         host_dstaddr, host_srcaddr, host_data});
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (ovf_clr) m_ovf = 1'b0;
    endtask

    task automatic check_outputs();
        check("access",   emesh_access_outb,   m_access);
        check("write",    emesh_write_outb,    m_out[102]);
        check("datamode", emesh_datamode_outb, m_out[101:100]);
        check("ctrlmode", emesh_ctrlmode_outb, m_out[99:96]);
        check("dstaddr",  emesh_dstaddr_outb,  m_out[95:64]);
        check("srcaddr",  emesh_srcaddr_outb,  m_out[63:32]);
        check("data",     emesh_data_outb,     m_out[31:0]);
        check("wr_full",  wr_full, exp_wr_q.size() == DEPTH);
        check("rd_full",  rd_full, exp_rd_q.size() == DEPTH);
        check("ovf_err",  ovf_err, m_ovf);
        check("wr_cnt",   wr_issue_cnt, m_wr_cnt);
        check("rd_cnt",   rd_issue_cnt, m_rd_cnt);
    endtask

    // One clock: predict, clock, sample #1 after the edge, compare.
    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outputs();
        if (emesh_access_outb === 1'b1) begin
            issues_seen++;
            order_log = {order_log[14:0], emesh_write_outb};
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push(input logic w, input logic [31:0] dst, input logic [31:0] dat);
        host_access   = 1'b1;
        host_write    = w;
        host_dstaddr  = dst;
        host_data     = dat;
        host_srcaddr  = $urandom;
        host_datamode = 2'($urandom_range(0, 3));
        host_ctrlmode = 4'($urandom_range(0, 15));
        step();
        host_access   = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        m_last_was_wr = 1'b0;
        m_out = '0;
        m_access = 1'b0;
        m_ovf = 1'b0;
        m_wr_cnt = '0;
        m_rd_cnt = '0;

        // Reset state
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        idle(2);

        // Single write: one issue, two edges after the push is applied
        issues_seen = 0;
        push(1'b1, 32'h8080_0000, 32'hDEAD_BEEF);
        check("single_not_yet", emesh_access_outb, 1'b0);
        step();
        check("single_dst",  emesh_dstaddr_outb, 32'h8080_0000);
        check("single_data", emesh_data_outb,    32'hDEAD_BEEF);
        idle(4);
        check("single_issue_count", issues_seen, 1);

        // Fill / overflow with write back-pressure
        emesh_wr_wait_inb = 1'b1;
        for (int i = 0; i < 8; i++) push(1'b1, 32'h1000 + i, 32'hA000 + i);
        check("fill_wr_full", wr_full, 1'b1);
        check("fill_no_ovf",  ovf_err, 1'b0);
        push(1'b1, 32'hBAD, 32'hBAD);
        check("ovf_set", ovf_err, 1'b1);
        issues_seen = 0;
        emesh_wr_wait_inb = 1'b0;
        idle(12);
        check("drain_issue_count", issues_seen, 8);
        // Set wins over clear when a drop and ovf_clr coincide
        emesh_rd_wait_inb = 1'b1;
        for (int i = 0; i < 8; i++) push(1'b0, 32'h2000 + i, i);
        ovf_clr = 1'b1;
        push(1'b0, 32'hBAD, 32'hBAD);
        check("ovf_set_wins", ovf_err, 1'b1);
        step();
        ovf_clr = 1'b0;
        check("ovf_cleared", ovf_err, 1'b0);
        emesh_rd_wait_inb = 1'b0;
        idle(10);

        // Round-robin from reset: W,R,W,R,W,R
        do_reset();
        emesh_wr_wait_inb = 1'b1;
        emesh_rd_wait_inb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(1'b1, 32'h3000 + i, i);
            push(1'b0, 32'h4000 + i, i);
        end
        issues_seen = 0;
        emesh_wr_wait_inb = 1'b0;
        emesh_rd_wait_inb = 1'b0;
        idle(8);
        check("rr_count", issues_seen, 6);
        check("rr_order", order_log[5:0], 6'b101010);

        // Independent back-pressure: only writes issue while rd_wait is high
        emesh_wr_wait_inb = 1'b1;
        emesh_rd_wait_inb = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(1'b1, 32'h5000 + i, i);
            push(1'b0, 32'h6000 + i, i);
        end
        issues_seen = 0;
        emesh_wr_wait_inb = 1'b0;
        idle(6);
        check("bp_writes_only", issues_seen, 3);
        check("bp_order", order_log[2:0], 3'b111);
        emesh_rd_wait_inb = 1'b0;
        issues_seen = 0;
        idle(6);
        check("bp_reads_after", issues_seen, 3);
        check("bp_read_order", order_log[2:0], 3'b000);

        // Reset mid-burst with 5 entries queued
        emesh_wr_wait_inb = 1'b1;
        emesh_rd_wait_inb = 1'b1;
        for (int i = 0; i < 3; i++) push(1'b1, 32'h7000 + i, i);
        for (int i = 0; i < 2; i++) push(1'b0, 32'h7100 + i, i);
        emesh_wr_wait_inb = 1'b0;
        emesh_rd_wait_inb = 1'b0;
        step();
        do_reset();
        check("rst_access", emesh_access_outb, 1'b0);
        check("rst_wr_full", wr_full, 1'b0);
        check("rst_rd_full", rd_full, 1'b0);
        issues_seen = 0;
        idle(10);
        check("rst_no_stale", issues_seen, 0);

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            host_access       = ($urandom_range(0, 3) != 0);
            host_write        = $urandom_range(0, 1);
            host_datamode     = 2'($urandom_range(0, 3));
            host_ctrlmode     = 4'($urandom_range(0, 15));
            host_dstaddr      = $urandom;
            host_srcaddr      = $urandom;
            host_data         = $urandom;
            emesh_wr_wait_inb = ($urandom_range(0, 2) == 0);
            emesh_rd_wait_inb = ($urandom_range(0, 2) == 0);
            ovf_clr           = ($urandom_range(0, 9) == 0);
            reset             = ($urandom_range(0, 499) == 0);
            step();
        end
        host_access = 1'b0;
        ovf_clr = 1'b0;
        reset = 1'b0;
        emesh_wr_wait_inb = 1'b0;
        emesh_rd_wait_inb = 1'b0;
        idle(20);

`ifdef EWRAPPER_TXQ_CNT_EN
        // Counter wrap: 0x10001 writes issued
        do_reset();
        host_access = 1'b1;
        host_write  = 1'b1;
        for (int i = 0; i < 32'h10001; i++) begin
            host_data = i;
            step();
        end
        host_access = 1'b0;
        idle(4);
        check("cnt_wr_wrap", wr_issue_cnt, 16'h0001);
        check("cnt_rd_zero", rd_issue_cnt, 16'h0000);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
